// File: rtl/dram_ref_reader.sv
// Reference-block reader: turns (addr, length) info pulses into in-order DRAM block reads and
// streams the returned blocks through a credit-protected FWFT FIFO. Optional: DRAM_REF_READER_STALL_CNT_EN.
module dram_ref_reader #(
  parameter int REF_LENGTH = 128,
  parameter int ADDR_WIDTH = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   ref_addr_in,
  input  logic [ADDR_WIDTH-1:0]   ref_length_in,
  input  logic                    ref_info_valid_in,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_addr_out,
  output logic                    mem_cmd_valid_out,
  input  logic                    mem_cmd_rdy_in,
  input  logic [2*REF_LENGTH-1:0] mem_rd_data_in,
  input  logic                    mem_rd_valid_in,
  output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
  output logic                    ref_seq_block_valid_out,
  input  logic                    ref_seq_block_rdy_in,
  output logic                    ref_done_out,
  output logic                    ref_overflow_out,
  output logic                    mem_err_out
`ifdef DRAM_REF_READER_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt_out
`endif
);

  localparam int BW = 2 * REF_LENGTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] delivered_q, delivered_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [IW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_WIDTH-1:0] pend_len_q, pend_len_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic [BW-1:0]         mem_q [FIFO_DEPTH];

  logic [IW-1:0]         occupancy;
  logic [IW-1:0]         credits;
  logic                  cmd_valid;
  logic                  cmd_fire;
  logic                  rd_ok;
  logic                  rd_stray;
  logic                  blk_valid;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] delivered_inc;
  logic                  xfer_done;

  // A credit covers one block either in flight or sitting in the FIFO, so writes can never overflow.
  always_comb begin
    occupancy     = inflight_q + count_q;
    credits       = IW'(FIFO_DEPTH) - occupancy;
    cmd_valid     = (state_q == S_ISSUE) && (credits != '0);
    cmd_fire      = cmd_valid && mem_cmd_rdy_in;
    rd_ok         = mem_rd_valid_in && (inflight_q != '0);
    rd_stray      = mem_rd_valid_in && (inflight_q == '0);
    blk_valid     = (count_q != '0);
    pop           = blk_valid && ref_seq_block_rdy_in;
    delivered_inc = delivered_q + ADDR_WIDTH'(pop);
    xfer_done     = (state_q == S_DRAIN) && (delivered_inc == len_q);
  end

  always_comb begin
    inflight_d = inflight_q + IW'(cmd_fire) - IW'(rd_ok);
    count_d    = count_q + IW'(rd_ok) - IW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(rd_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    err_d      = err_q | rd_stray;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_len_d  = pend_len_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;

    if (cmd_fire) begin
      addr_d   = addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
    end
    if (pop) delivered_d = delivered_inc;

    case (state_q)
      S_IDLE: begin
        if (ref_info_valid_in) begin
          addr_d      = ref_addr_in;
          len_d       = ref_length_in;
          issued_d    = '0;
          delivered_d = '0;
          if (ref_length_in != '0) state_d = S_ISSUE;
          else                     done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cmd_fire && ((issued_q + 1'b1) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A zero-length follow-on stays in DRAIN one cycle so it yields its own done pulse.
        if (xfer_done) begin
          done_d      = 1'b1;
          issued_d    = '0;
          delivered_d = '0;
          if (pend_vld_q) begin
            addr_d     = pend_addr_q;
            len_d      = pend_len_q;
            pend_vld_d = 1'b0;
            state_d    = (pend_len_q != '0) ? S_ISSUE : S_DRAIN;
          end else if (ref_info_valid_in) begin
            addr_d  = ref_addr_in;
            len_d   = ref_length_in;
            state_d = (ref_length_in != '0) ? S_ISSUE : S_DRAIN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ref_info_valid_in && (state_q != S_IDLE) && !(xfer_done && !pend_vld_q)) begin
      if (!pend_vld_q || xfer_done) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = ref_addr_in;
        pend_len_d  = ref_length_in;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_len_q  <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_len_q  <= pend_len_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  // Block storage carries data only; the pointers and count above define what is valid.
  always_ff @(posedge clk) begin
    if (rd_ok) mem_q[wr_ptr_q] <= mem_rd_data_in;
  end

`ifdef DRAM_REF_READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        start_xfer;

  always_comb begin
    start_xfer = ((state_q == S_IDLE) && ref_info_valid_in && (ref_length_in != '0)) ||
                 (xfer_done && (pend_vld_q ? (pend_len_q != '0)
                                           : (ref_info_valid_in && (ref_length_in != '0))));
    stall_d = stall_q;
    if (start_xfer) stall_d = '0;
    else if (blk_valid && !ref_seq_block_rdy_in && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt_out = stall_q;
`endif

  assign mem_cmd_addr_out        = addr_q;
  assign mem_cmd_valid_out       = cmd_valid;
  assign ref_seq_block_valid_out = blk_valid;
  assign ref_seq_block_out       = blk_valid ? mem_q[rd_ptr_q] : '0;
  assign ref_done_out            = done_q;
  assign ref_overflow_out        = ovf_q;
  assign mem_err_out             = err_q;

endmodule
